cond_ctrl_pipe: RTL

Parametrised control pipeline for the pipelined CPU. It takes the decoded control bundle from the D stage and carries it through NSTG post-decode stages (E, M, W, ...). Condition evaluation uses full 4-bit condition codes against a split-write NZCV flags register, and gating is applied at E. It also adds a multi-cycle execute FSM (MUL/DIV/MOD) that holds E and back-pressures the front end, and it produces the PC-write-pending hazard hint across all pre-writeback stages.

---
 rtl/cond_ctrl_pipe.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/cond_ctrl_pipe.sv
// Post-decode control pipeline: conditional gating at E, split-write NZCV flags,
// multi-cycle execute stall FSM and PC-write-pending hazard hint.
module cond_ctrl_pipe #(
  parameter int CW     = 8,
  parameter int NSTG   = 3,
  parameter int MC_LAT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_e,
  input  logic                   dec_valid,
  input  logic [CW-1:0]          dec_ctrl,
  input  logic [3:0]             dec_cond,
  input  logic [1:0]             dec_flagwr,
  input  logic                   dec_regwr,
  input  logic                   dec_memwr,
  input  logic                   dec_branch,
  input  logic                   dec_pcsrc,
  input  logic                   dec_mc,
  input  logic [3:0]             alu_flags_e,
  output logic [CW-1:0]          ctrl_e,
  output logic                   cond_ex_e,
  output logic                   branch_taken_e,
  output logic [3:0]             flags_q,
  output logic [(NSTG-1)*CW-1:0] ctrl_pipe,
  output logic [NSTG-2:0]        regwr_pipe,
  output logic [NSTG-2:0]        memwr_pipe,
  output logic [NSTG-2:0]        pcsrc_pipe,
  output logic                   mc_stall,
  output logic                   pc_wr_pending
);

  localparam int                CNT_W    = $clog2(MC_LAT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MC_LAT - 1);
  localparam logic              MC_EN    = (MC_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_e_q, valid_e_d;
  logic [CW-1:0]       ctrl_e_q, ctrl_e_d;
  logic [3:0]          cond_e_q, cond_e_d;
  logic [1:0]          flagwr_e_q, flagwr_e_d;
  logic                regwr_e_q, regwr_e_d, memwr_e_q, memwr_e_d;
  logic                branch_e_q, branch_e_d, pcsrc_e_q, pcsrc_e_d, mc_e_q, mc_e_d;
  logic [3:0]          flags_d;
  logic [(NSTG-1)*CW-1:0] ctrl_pipe_q, ctrl_pipe_d;
  logic [NSTG-2:0]     regwr_pipe_q, regwr_pipe_d, memwr_pipe_q, memwr_pipe_d;
  logic [NSTG-2:0]     pcsrc_pipe_q, pcsrc_pipe_d;
  logic                mc_start, advance;

  // E stage: condition check and stall decision
  always_comb begin
    cond_ex_e      = valid_e_q & cond_pass(cond_e_q, flags_q);
    mc_start       = cond_ex_e & mc_e_q & MC_EN;
    mc_stall       = (state_q == BUSY) ? (cnt_q != CNT_LAST) : mc_start;
    advance        = ~mc_stall;
    branch_taken_e = branch_e_q & cond_ex_e & advance;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (mc_start) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(1);
      end
      BUSY: if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // D -> E capture; a stall holds E and overrides flush
  always_comb begin
    valid_e_d  = valid_e_q;
    ctrl_e_d   = ctrl_e_q;
    cond_e_d   = cond_e_q;
    flagwr_e_d = flagwr_e_q;
    regwr_e_d  = regwr_e_q;
    memwr_e_d  = memwr_e_q;
    branch_e_d = branch_e_q;
    pcsrc_e_d  = pcsrc_e_q;
    mc_e_d     = mc_e_q;
    if (advance) begin
      if (flush_e) begin
        valid_e_d  = 1'b0;
        ctrl_e_d   = '0;
        cond_e_d   = '0;
        flagwr_e_d = '0;
        regwr_e_d  = 1'b0;
        memwr_e_d  = 1'b0;
        branch_e_d = 1'b0;
        pcsrc_e_d  = 1'b0;
        mc_e_d     = 1'b0;
      end else begin
        valid_e_d  = dec_valid;
        ctrl_e_d   = dec_ctrl;
        cond_e_d   = dec_cond;
        flagwr_e_d = dec_flagwr;
        regwr_e_d  = dec_regwr;
        memwr_e_d  = dec_memwr;
        branch_e_d = dec_branch;
        pcsrc_e_d  = dec_pcsrc;
        mc_e_d     = dec_mc;
      end
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (cond_ex_e & advance) begin
      if (flagwr_e_q[1]) flags_d[3:2] = alu_flags_e[3:2];
      if (flagwr_e_q[0]) flags_d[1:0] = alu_flags_e[1:0];
    end
  end

  // E -> stage 1 takes gated enables; later stages shift unconditionally
  always_comb begin
    ctrl_pipe_d  = '0;
    regwr_pipe_d = '0;
    memwr_pipe_d = '0;
    pcsrc_pipe_d = '0;
    if (advance) begin
      ctrl_pipe_d[CW-1:0] = ctrl_e_q;
      regwr_pipe_d[0]     = regwr_e_q & cond_ex_e;
      memwr_pipe_d[0]     = memwr_e_q & cond_ex_e;
      pcsrc_pipe_d[0]     = pcsrc_e_q & cond_ex_e;
    end
    for (int k = 2; k < NSTG; k++) begin
      ctrl_pipe_d[k*CW-1 -: CW] = ctrl_pipe_q[(k-1)*CW-1 -: CW];
      regwr_pipe_d[k-1]         = regwr_pipe_q[k-2];
      memwr_pipe_d[k-1]         = memwr_pipe_q[k-2];
      pcsrc_pipe_d[k-1]         = pcsrc_pipe_q[k-2];
    end
  end

  // Writeback stage is excluded: its PC write is already visible to fetch
  always_comb begin
    pc_wr_pending = (dec_valid & dec_pcsrc) | (valid_e_q & pcsrc_e_q);
    for (int k = 0; k < NSTG - 2; k++) begin
      pc_wr_pending = pc_wr_pending | pcsrc_pipe_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      valid_e_q    <= 1'b0;
      ctrl_e_q     <= '0;
      cond_e_q     <= '0;
      flagwr_e_q   <= '0;
      regwr_e_q    <= 1'b0;
      memwr_e_q    <= 1'b0;
      branch_e_q   <= 1'b0;
      pcsrc_e_q    <= 1'b0;
      mc_e_q       <= 1'b0;
      flags_q      <= '0;
      ctrl_pipe_q  <= '0;
      regwr_pipe_q <= '0;
      memwr_pipe_q <= '0;
      pcsrc_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_e_q    <= valid_e_d;
      ctrl_e_q     <= ctrl_e_d;
      cond_e_q     <= cond_e_d;
      flagwr_e_q   <= flagwr_e_d;
      regwr_e_q    <= regwr_e_d;
      memwr_e_q    <= memwr_e_d;
      branch_e_q   <= branch_e_d;
      pcsrc_e_q    <= pcsrc_e_d;
      mc_e_q       <= mc_e_d;
      flags_q      <= flags_d;
      ctrl_pipe_q  <= ctrl_pipe_d;
      regwr_pipe_q <= regwr_pipe_d;
      memwr_pipe_q <= memwr_pipe_d;
      pcsrc_pipe_q <= pcsrc_pipe_d;
    end
  end

  assign ctrl_e     = ctrl_e_q;
  assign ctrl_pipe  = ctrl_pipe_q;
  assign regwr_pipe = regwr_pipe_q;
  assign memwr_pipe = memwr_pipe_q;
  assign pcsrc_pipe = pcsrc_pipe_q;

endmodule
